reg_alu_sequencer: RTL
======================

Name: reg_alu_sequencer

Overview:
- Multi-cycle controller directly upstream and downstream of the 16x8 register unit.
- Accepts one register-to-register instruction and reads operand A, then operand B, through the register unit's single addr/data_out port.
- Computes an 8-bit ALU result and writes it back via load/data_in.
- Raises done and reports carry and zero flags.

Parameters:
- DATA_W, 8, operand/result width; must match the register unit's data width.
- ADDR_W, 4, register address width (16 registers).
- RD_LAT, 1, cycles between the register unit capturing addr and data_out being valid to sample.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; top level drives the register unit's reset from ~reset.
- start  in  1  request; sampled only in IDLE.
- opcode  in  3  operation select.
- src_a  in  ADDR_W  operand A register.
- src_b  in  ADDR_W  operand B register.
- dst  in  ADDR_W  destination register.
- rf_addr  out  ADDR_W  to register unit addr.
- rf_load  out  1  to register unit load.
- rf_wdata  out  DATA_W  to register unit data_in.
- rf_rdata  in  DATA_W  from register unit data_out.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- result  out  DATA_W  last computed result.
- carry  out  1  carry/borrow flag.
- zero  out  1  result==0 flag.

Behaviour:
- Reset:
  - reset==0 at a rising edge forces state IDLE.
  - rf_addr, rf_load, rf_wdata, busy, done, result, carry, zero and the internal operand/instruction registers all clear to 0.
  - Reset in any state aborts the operation; no write-back is issued in that cycle or later.
- States: IDLE -> RD_A -> RD_B -> EXEC -> WB -> DONE -> IDLE.
- IDLE:
  - On start==1, latch opcode, src_a, src_b and dst, then go to RD_A.
  - Later changes on these inputs are ignored until the next IDLE.
- RD_A:
  - rf_addr=src_a for RD_LAT+1 cycles, timed by a counter.
  - On the edge ending the last cycle, opa<=rf_rdata.
- RD_B: same as RD_A using src_b; captures opb.
- EXEC: result, carry and zero are registered at the end of the cycle.
- WB: rf_addr=dst, rf_wdata=result, rf_load=1 for exactly one cycle.
- DONE: done=1 for one cycle, then return to IDLE.
- busy=1 in RD_A through WB; busy=0 in IDLE and DONE.
- start outside IDLE is ignored, not queued. start held high re-triggers on the first IDLE cycle.
- Latency with RD_LAT=1: start sampled at cycle 0 gives rf_load in cycle 6 and done in cycle 7. Generally, done arrives 2*(RD_LAT+1)+3 cycles after start.
- rf_load=0 in every state except WB. rf_addr holds 0 in IDLE/EXEC/DONE.
- Opcodes (all arithmetic modulo 2^DATA_W):
  - 000 ADD: carry = carry-out.
  - 001 SUB A-B: carry = borrow (A<B unsigned).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT A.
  - 110 SHL A by 1: carry = A[7], LSB=0.
  - 111 PASS A.
  - carry=0 for every opcode not listed with a carry rule.
- zero = (result==0) for every opcode.
- Flags and result hold their values until the next EXEC.
- dst may equal src_a or src_b; operands are already captured before WB, so there is no hazard.

Optional Feature:
- Macro: REG_SEQ_OPERAND_SKIP_EN.
- Defined: RD_B is skipped and opb<=opa whenever src_a==src_b or opcode is unary (101, 110, 111). Latency drops by RD_LAT+1 (done at cycle 5 for RD_LAT=1).
- Undefined: RD_B always executes; latency is fixed.
- Results are identical either way.

Decomposition:
- Package reg_seq_pkg contains:
  - opcode localparams (OP_ADD..OP_PASS);
  - state encoding localparams;
  - DATA_W/ADDR_W defaults.
- Sub-module reg_seq_alu: combinational (opcode, a, b) -> (result, carry, zero). The FSM registers its outputs in EXEC.

Test Plan:
- Reset: drive reset=0 during WB of an ADD -> rf_load=0 that cycle; all outputs 0; IDLE; no done pulse.
- ADD, R1=0x7F, R2=0x01, dst=R3, RD_LAT=1:
  - rf_addr=1 in cycles 1-2 and 2 in cycles 3-4;
  - cycle 6: rf_load=1, rf_addr=3, rf_wdata=0x80;
  - cycle 7: done=1, carry=0, zero=0.
- ADD 0xFF+0x01 -> result=0x00, carry=1, zero=1; register file R3 reads back 0x00.
- SUB 0x05-0x07 -> 0xFE, carry=1. SHL 0x81 -> 0x02, carry=1.
- Hold start=1 continuously -> second op accepted at cycle 8 (first IDLE). A start pulse at cycle 3 is ignored.
- ADD R4+R4 with R4=0x40 -> 0x80. Done at cycle 5 with REG_SEQ_OPERAND_SKIP_EN, cycle 7 without.

Source files
------------

// File: rtl/reg_seq_pkg.sv
// Shared opcode/state encodings and default widths for the register ALU sequencer.
// Pure constants and types; no logic, no latency.
package reg_seq_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    typedef logic [2:0] opcode_t;
    typedef logic [2:0] state_t;

    localparam opcode_t OP_ADD  = 3'b000;
    localparam opcode_t OP_SUB  = 3'b001;
    localparam opcode_t OP_AND  = 3'b010;
    localparam opcode_t OP_OR   = 3'b011;
    localparam opcode_t OP_XOR  = 3'b100;
    localparam opcode_t OP_NOT  = 3'b101;
    localparam opcode_t OP_SHL  = 3'b110;
    localparam opcode_t OP_PASS = 3'b111;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_RD_A = 3'd1;
    localparam state_t S_RD_B = 3'd2;
    localparam state_t S_EXEC = 3'd3;
    localparam state_t S_WB   = 3'd4;
    localparam state_t S_DONE = 3'd5;

endpackage

// File: rtl/reg_alu_sequencer_if.sv
// Instruction request, register-unit port and status bundle of the sequencer.
// slave = the sequencer itself; master = requester plus register unit side.
interface reg_alu_sequencer_if #(
    parameter int DATA_W = reg_seq_pkg::DATA_W_DEF,
    parameter int ADDR_W = reg_seq_pkg::ADDR_W_DEF
);
    logic              start;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] rf_addr;
    logic              rf_load;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              zero;

    modport slave (
        input  start, opcode, src_a, src_b, dst, rf_rdata,
        output rf_addr, rf_load, rf_wdata, busy, done, result, carry, zero
    );

    modport master (
        output start, opcode, src_a, src_b, dst, rf_rdata,
        input  rf_addr, rf_load, rf_wdata, busy, done, result, carry, zero
    );
endinterface

// File: rtl/reg_seq_alu.sv
// Combinational 8-op ALU producing result, carry/borrow and zero flag.
// Zero latency; no handshake, the caller registers the outputs.
module reg_seq_alu
    import reg_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  opcode_t           opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // The extra top bit is the carry-out for ADD and the borrow for SUB.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (opcode)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB: begin
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            default: result = a;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/reg_alu_sequencer.sv
// Reads A then B through the register unit, runs the ALU, writes back; REG_SEQ_OPERAND_SKIP_EN skips RD_B for unary/same-register ops.
// start->done takes 2*(RD_LAT+1)+3 cycles; no backpressure, start is ignored outside IDLE.
module reg_alu_sequencer
    import reg_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic                clock,
    input  logic                reset,
    reg_alu_sequencer_if.slave  bus
);

    localparam int             CNT_W    = $clog2(RD_LAT + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              last;
    logic              skip;
    opcode_t           op_q;
    logic [ADDR_W-1:0] sa_q;
    logic [ADDR_W-1:0] sb_q;
    logic [ADDR_W-1:0] d_q;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] res_q;
    logic              carry_q;
    logic              zero_q;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_z;

    assign last = (cnt == CNT_LAST);

`ifdef REG_SEQ_OPERAND_SKIP_EN
    assign skip = (sa_q == sb_q) || (op_q == OP_NOT) || (op_q == OP_SHL) || (op_q == OP_PASS);
`else
    assign skip = 1'b0;
`endif

    reg_seq_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode (op_q),
        .a      (opa),
        .b      (opb),
        .result (alu_res),
        .carry  (alu_c),
        .zero   (alu_z)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_RD_A;
            S_RD_A: if (last)      state_nxt = skip ? S_EXEC : S_RD_B;
            S_RD_B: if (last)      state_nxt = S_EXEC;
            S_EXEC:                state_nxt = S_WB;
            S_WB:                  state_nxt = S_DONE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // Read counter restarts at every read phase so each operand gets RD_LAT+1 cycles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt     <= '0;
            op_q    <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            d_q     <= '0;
            opa     <= '0;
            opb     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            if ((state == S_RD_A || state == S_RD_B) && !last) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (state == S_IDLE && bus.start) begin
                op_q <= bus.opcode;
                sa_q <= bus.src_a;
                sb_q <= bus.src_b;
                d_q  <= bus.dst;
            end
            if (state == S_RD_A && last) begin
                opa <= bus.rf_rdata;
                if (skip) begin
                    opb <= bus.rf_rdata;
                end
            end
            if (state == S_RD_B && last) begin
                opb <= bus.rf_rdata;
            end
            if (state == S_EXEC) begin
                res_q   <= alu_res;
                carry_q <= alu_c;
                zero_q  <= alu_z;
            end
        end
    end

    // Write-back is gated by reset so an abort in WB never reaches the register unit.
    always_comb begin
        bus.rf_addr  = '0;
        bus.rf_load  = 1'b0;
        bus.rf_wdata = '0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (state)
            S_RD_A: begin
                bus.rf_addr = sa_q;
                bus.busy    = 1'b1;
            end
            S_RD_B: begin
                bus.rf_addr = sb_q;
                bus.busy    = 1'b1;
            end
            S_EXEC: bus.busy = 1'b1;
            S_WB: begin
                bus.rf_addr  = d_q;
                bus.rf_wdata = res_q;
                bus.rf_load  = reset;
                bus.busy     = 1'b1;
            end
            S_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.result = res_q;
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;

endmodule
